key_debouncer: RTL



---
 rtl/key_debouncer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/key_debouncer.sv
// Pushbutton conditioner: 2-flop sync, per-key debounce FSM, press/release strobes.
// Optional auto-repeat on key_press when KEY_AUTOREPEAT_EN is defined.
module key_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CONE = CW'(1);

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RONE = RW'(1);
`endif

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [NUM_KEYS-1:0] s1;
  logic [NUM_KEYS-1:0] s2;
  logic [NUM_KEYS-1:0] ks;

  // KEY is active-low and async; idle (released) sync value is 1
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= KEY;
      s2 <= s1;
    end
  end

  assign ks = ~s2;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_t          st;
    state_t          st_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            held;
    logic            held_n;
    logic            prs;
    logic            prs_n;
    logic            rel;
    logic            rel_n;
`ifdef KEY_AUTOREPEAT_EN
    logic [RW-1:0]   rcnt;
    logic [RW-1:0]   rcnt_n;
    logic            rfst;
    logic            rfst_n;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        st   <= RELEASED;
        cnt  <= '0;
        held <= 1'b0;
        prs  <= 1'b0;
        rel  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt <= '0;
        rfst <= 1'b1;
`endif
      end else begin
        st   <= st_n;
        cnt  <= cnt_n;
        held <= held_n;
        prs  <= prs_n;
        rel  <= rel_n;
`ifdef KEY_AUTOREPEAT_EN
        rcnt <= rcnt_n;
        rfst <= rfst_n;
`endif
      end
    end

    always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      held_n = held;
      prs_n  = 1'b0;
      rel_n  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rcnt_n = '0;
      rfst_n = 1'b1;
`endif
      unique case (st)
        RELEASED: begin
          if (ks[i]) begin
            st_n  = PRESS_WAIT;
            cnt_n = CONE;
          end
        end
        PRESS_WAIT: begin
          if (!ks[i]) begin
            st_n  = RELEASED;
            cnt_n = '0;
          end else if (cnt == CMAX) begin
            st_n   = PRESSED;
            cnt_n  = '0;
            held_n = 1'b1;
            prs_n  = 1'b1;
          end else begin
            cnt_n = cnt + CONE;
          end
        end
        PRESSED: begin
          if (!ks[i]) begin
            st_n  = RELEASE_WAIT;
            cnt_n = CONE;
          end else begin
`ifdef KEY_AUTOREPEAT_EN
            // first strobe after the delay, then one per period
            rfst_n = rfst;
            if (rfst && rcnt == RDLY) begin
              prs_n  = 1'b1;
              rfst_n = 1'b0;
            end else if (!rfst && rcnt == RPER) begin
              prs_n = 1'b1;
            end else begin
              rcnt_n = rcnt + RONE;
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (ks[i]) begin
            st_n  = PRESSED;
            cnt_n = '0;
          end else if (cnt == CMAX) begin
            st_n   = RELEASED;
            cnt_n  = '0;
            held_n = 1'b0;
            rel_n  = 1'b1;
          end else begin
            cnt_n = cnt + CONE;
          end
        end
        default: begin
          st_n  = RELEASED;
          cnt_n = '0;
        end
      endcase
    end

    assign key_held[i]    = held;
    assign key_press[i]   = prs;
    assign key_release[i] = rel;
  end

endmodule
